cache_miss_handler: RTL
=======================

CACHE_MISS_HANDLER -- requirements
Module: cache_miss_handler

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 64, bus word width; ADDR_WIDTH, 64, address width; CHUNKS_LOG, 4, log2 of words per line; LINE_W = DATA_WIDTH*2**CHUNKS_LOG, derived; OFF_W = CHUNKS_LOG+log2(DATA_WIDTH/8), derived, line-offset bits.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 miss_valid / miss_ready  in / out  1 / 1  cache miss request handshake.
REQ-006 miss_addr  in  ADDR_WIDTH  missing byte address.
REQ-007 miss_dirty  in  1  victim line dirty.
REQ-008 victim_addr  in  ADDR_WIDTH  victim line address.
REQ-009 victim_data  in  LINE_W  victim line data.
REQ-010 command_valid, command_store, command_rready  out  1 each  bus command (one slot of the cache-memory bus).
REQ-011 command_addr  out  ADDR_WIDTH  bus address, low OFF_W bits always 0.
REQ-012 data_in  out  LINE_W  writeback line to bus.
REQ-013 bus_valid / bus_ready  in / in  1 / 1  this slot's bus response valid / bus idle-and-granted.
REQ-014 data_out  in  LINE_W  fill line from bus.
REQ-015 invalidate  in  1, invalidate_addr  in  ADDR_WIDTH  snoop invalidate from bus.
REQ-016 fill_valid  out  1, fill_addr  out  ADDR_WIDTH, fill_data  out  LINE_W, fill_word  out  DATA_WIDTH, fill_stale  out  1  one-cycle fill result to cache arrays.
REQ-017 miss_count, wb_count  out  32 each  saturating event counters.

Function
REQ-018 FSM states SHALL be IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, DONE.
REQ-019 IDLE: miss_ready=1; on miss_valid capture miss_addr, miss_dirty, victim_addr, victim_data; go WB_REQ if miss_dirty else FILL_REQ; miss_count+1.
REQ-020 miss_ready SHALL be 1 only in IDLE; inputs ignored elsewhere.
REQ-021 WB_REQ: command_valid=1, command_store=1, command_addr=victim line addr, data_in=victim data; on bus_ready=1 same cycle -> WB_WAIT, wb_count+1.
REQ-022 WB_WAIT: command_valid=0; bus_ready must first drop (bus busy flag set), then next bus_ready=1 -> FILL_REQ.
REQ-023 FILL_REQ: command_valid=1, command_store=0, command_addr=miss_addr with low OFF_W bits cleared; on bus_ready=1 -> FILL_WAIT.
REQ-024 FILL_WAIT: command_valid=0, command_rready=1; on bus_valid=1 capture data_out -> DONE.
REQ-025 DONE: fill_valid=1 for exactly one cycle, fill_addr=line addr, fill_data=captured line, fill_word=word index miss_addr[OFF_W-1:OFF_W-CHUNKS_LOG]; -> IDLE.
REQ-026 command_addr/data_in/command_store SHALL stay stable while command_valid=1.
REQ-027 Stale tracking: invalidate=1 with invalidate_addr line == pending fill line in FILL_REQ or FILL_WAIT, or the cycle of bus_valid, SHALL set stale; fill_stale=stale in DONE; stale cleared on entering IDLE.
REQ-028 Invalidate in WB_* or of victim line SHALL not alter writeback.
REQ-029 Invalidate in IDLE same cycle as miss acceptance matching miss line SHALL not set stale.
REQ-030 Counters SHALL saturate at 32'hFFFF_FFFF, no wrap.
REQ-031 Latency: clean miss, bus ready immediately, bus_valid N cycles after grant -> fill_valid N+2 cycles after acceptance.
REQ-032 Outputs in unused states SHALL be 0 (data buses 0 except fill_data/fill_word hold last value).

Reset
REQ-033 reset_n=0 SHALL asynchronously force IDLE, all command_*, fill_valid, fill_stale, stale=0, captured registers 0, counters 0.
REQ-034 Reset mid-transaction SHALL abandon it with no fill_valid; first cycle after release miss_ready=1.

Verification
REQ-035 Clean miss addr 0x1048, bus_ready=1, bus_valid 5 cycles later -> command_addr 0x1000, store=0, one fill_valid, fill_word=word 9, miss_count=1.
REQ-036 Dirty miss victim 0x2000 -> store command addr 0x2000 with victim data, bus_ready low-high, then load 0x1000; wb_count=1.
REQ-037 Invalidate 0x1010 during FILL_WAIT for line 0x1000 -> fill_stale=1; next miss fill_stale=0.
REQ-038 bus_ready held 0 for 20 cycles in FILL_REQ -> command_valid held, addr stable, no fill.
REQ-039 reset_n low in WB_WAIT -> all outputs 0 asynchronously, no fill_valid after release.
REQ-040 Counter preloaded 32'hFFFF_FFFF via force, one miss -> stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/cache_miss_handler.sv
// Cache miss handler: optional dirty-victim writeback, then a line fill from the
// shared cache-memory bus, with snoop-invalidate tracking on the pending fill line.
module cache_miss_handler #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64,
   parameter int CHUNKS_LOG = 4,
   localparam int LINE_W = DATA_WIDTH * (2 ** CHUNKS_LOG),
   localparam int OFF_W = CHUNKS_LOG + $clog2(DATA_WIDTH / 8)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  miss_valid,
   output logic                  miss_ready,
   input  logic [ADDR_WIDTH-1:0] miss_addr,
   input  logic                  miss_dirty,
   input  logic [ADDR_WIDTH-1:0] victim_addr,
   input  logic [LINE_W-1:0]     victim_data,
   output logic                  command_valid,
   output logic                  command_store,
   output logic                  command_rready,
   output logic [ADDR_WIDTH-1:0] command_addr,
   output logic [LINE_W-1:0]     data_in,
   input  logic                  bus_valid,
   input  logic                  bus_ready,
   input  logic [LINE_W-1:0]     data_out,
   input  logic                  invalidate,
   input  logic [ADDR_WIDTH-1:0] invalidate_addr,
   output logic                  fill_valid,
   output logic [ADDR_WIDTH-1:0] fill_addr,
   output logic [LINE_W-1:0]     fill_data,
   output logic [DATA_WIDTH-1:0] fill_word,
   output logic                  fill_stale,
   output logic [31:0]           miss_count,
   output logic [31:0]           wb_count
);

   typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] miss_addr_q, victim_addr_q, miss_line;
   logic [LINE_W-1:0]     victim_data_q, fill_line_q;
   logic [DATA_WIDTH-1:0] fill_word_q;
   logic [CHUNKS_LOG-1:0] word_idx;
   logic [31:0]           miss_cnt, wb_cnt;
   logic                  stale, busy_seen, accept, inv_hit;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign accept     = (state == IDLE) && miss_valid;
   assign miss_line  = miss_addr_q & LINE_MASK;
   assign word_idx   = miss_addr_q[OFF_W-1 -: CHUNKS_LOG];
   assign inv_hit    = invalidate && ((invalidate_addr & LINE_MASK) == miss_line);
   assign fill_data  = fill_line_q;
   assign fill_word  = fill_word_q;
   assign miss_count = miss_cnt;
   assign wb_count   = wb_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         miss_addr_q   <= '0;
         victim_addr_q <= '0;
         victim_data_q <= '0;
         fill_line_q   <= '0;
         fill_word_q   <= '0;
         stale         <= 1'b0;
         busy_seen     <= 1'b0;
         miss_cnt      <= '0;
         wb_cnt        <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            miss_addr_q   <= miss_addr;
            victim_addr_q <= victim_addr;
            victim_data_q <= victim_data;
            miss_cnt      <= sat_inc(miss_cnt);
         end
         if (state == WB_REQ && bus_ready)
            wb_cnt <= sat_inc(wb_cnt);
         // the writeback is only complete once the bus has gone busy and come back
         busy_seen <= (state == WB_WAIT) && (busy_seen || !bus_ready);
         if (state == DONE)
            stale <= 1'b0;
         else if ((state == FILL_REQ || state == FILL_WAIT) && inv_hit)
            stale <= 1'b1;
         if (state == FILL_WAIT && bus_valid) begin
            fill_line_q <= data_out;
            fill_word_q <= data_out[word_idx * DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      miss_ready     = 1'b0;
      command_valid  = 1'b0;
      command_store  = 1'b0;
      command_rready = 1'b0;
      command_addr   = '0;
      data_in        = '0;
      fill_valid     = 1'b0;
      fill_addr      = '0;
      fill_stale     = 1'b0;
      case (state)
         IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid) state_nxt = miss_dirty ? WB_REQ : FILL_REQ;
         end
         WB_REQ: begin
            command_valid = 1'b1;
            command_store = 1'b1;
            command_addr  = victim_addr_q & LINE_MASK;
            data_in       = victim_data_q;
            if (bus_ready) state_nxt = WB_WAIT;
         end
         WB_WAIT: begin
            if (busy_seen && bus_ready) state_nxt = FILL_REQ;
         end
         FILL_REQ: begin
            command_valid = 1'b1;
            command_addr  = miss_line;
            if (bus_ready) state_nxt = FILL_WAIT;
         end
         FILL_WAIT: begin
            command_rready = 1'b1;
            if (bus_valid) state_nxt = DONE;
         end
         DONE: begin
            fill_valid = 1'b1;
            fill_addr  = miss_line;
            fill_stale = stale;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
